// File: rtl/apb2axi_bridge.sv
// APB slave to AXI4 master bridge: every APB access becomes one single-beat AXI4 transaction.
// Optional APB4 write strobe support is enabled by defining APB2AXI_PSTRB_EN.
module apb2axi_bridge #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned APB_ADDR_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic [31:0]               pwdata,
  input  logic                      pwrite,
  input  logic                      psel,
  input  logic                      penable,
`ifdef APB2AXI_PSTRB_EN
  input  logic [3:0]                pstrb,
`endif
  output logic [31:0]               prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic [AXI_ID_WIDTH-1:0]   aw_id,
  output logic [AXI_ADDR_WIDTH-1:0] aw_addr,
  output logic [7:0]                aw_len,
  output logic [2:0]                aw_size,
  output logic [1:0]                aw_burst,
  output logic                      aw_lock,
  output logic [3:0]                aw_cache,
  output logic [2:0]                aw_prot,
  output logic [3:0]                aw_region,
  output logic [3:0]                aw_qos,
  output logic [AXI_USER_WIDTH-1:0] aw_user,
  output logic                      aw_valid,
  input  logic                      aw_ready,
  output logic [31:0]               w_data,
  output logic [3:0]                w_strb,
  output logic                      w_last,
  output logic [AXI_USER_WIDTH-1:0] w_user,
  output logic                      w_valid,
  input  logic                      w_ready,
  input  logic [AXI_ID_WIDTH-1:0]   b_id,
  input  logic [1:0]                b_resp,
  input  logic [AXI_USER_WIDTH-1:0] b_user,
  input  logic                      b_valid,
  output logic                      b_ready,
  output logic [AXI_ID_WIDTH-1:0]   ar_id,
  output logic [AXI_ADDR_WIDTH-1:0] ar_addr,
  output logic [7:0]                ar_len,
  output logic [2:0]                ar_size,
  output logic [1:0]                ar_burst,
  output logic                      ar_lock,
  output logic [3:0]                ar_cache,
  output logic [2:0]                ar_prot,
  output logic [3:0]                ar_region,
  output logic [3:0]                ar_qos,
  output logic [AXI_USER_WIDTH-1:0] ar_user,
  output logic                      ar_valid,
  input  logic                      ar_ready,
  input  logic [AXI_ID_WIDTH-1:0]   r_id,
  input  logic [31:0]               r_data,
  input  logic [1:0]                r_resp,
  input  logic                      r_last,
  input  logic [AXI_USER_WIDTH-1:0] r_user,
  input  logic                      r_valid,
  output logic                      r_ready
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

  state_t                    state, state_nxt;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]               wdata_q;
  logic                      aw_done, w_done;
  logic                      unused_inputs;

  // Response IDs/user fields and the low response bit carry no information for APB.
  assign unused_inputs = ^{b_id, b_user, r_id, r_user, b_resp[0], r_resp[0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      prdata  <= '0;
      pslverr <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (psel && penable) begin
          addr_q  <= paddr;
          wdata_q <= pwdata;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          pslverr <= 1'b0;
          if (pwrite) prdata <= '0;
        end
        WR_REQ: begin
          if (aw_valid && aw_ready) aw_done <= 1'b1;
          if (w_valid && w_ready) w_done <= 1'b1;
        end
        WR_RESP: if (b_valid) pslverr <= b_resp[1];
        RD_RESP: if (r_valid) begin
          prdata  <= r_data;
          pslverr <= r_resp[1] | ~r_last;
        end
        default: ;
      endcase
    end
  end

`ifdef APB2AXI_PSTRB_EN
  logic [3:0] strb_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) strb_q <= '0;
    else if (state == IDLE && psel && penable) strb_q <= pstrb;
  end

  assign w_strb = strb_q;
`else
  assign w_strb = 4'hF;
`endif

  always_comb begin
    state_nxt = state;
    aw_valid  = 1'b0;
    w_valid   = 1'b0;
    b_ready   = 1'b0;
    ar_valid  = 1'b0;
    r_ready   = 1'b0;
    pready    = 1'b0;
    unique case (state)
      IDLE:    if (psel && penable) state_nxt = pwrite ? WR_REQ : RD_REQ;
      WR_REQ: begin
        aw_valid = ~aw_done;
        w_valid  = ~w_done;
        // Both channels may complete in either order or together.
        if ((aw_done || aw_ready) && (w_done || w_ready)) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        b_ready = 1'b1;
        if (b_valid) state_nxt = DONE;
      end
      RD_REQ: begin
        ar_valid = 1'b1;
        if (ar_ready) state_nxt = RD_RESP;
      end
      RD_RESP: begin
        r_ready = 1'b1;
        if (r_valid) state_nxt = DONE;
      end
      DONE: begin
        pready    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign aw_id     = '0;
  assign aw_addr   = AXI_ADDR_WIDTH'(addr_q);
  assign aw_len    = '0;
  assign aw_size   = 3'b010;
  assign aw_burst  = 2'b01;
  assign aw_lock   = 1'b0;
  assign aw_cache  = '0;
  assign aw_prot   = '0;
  assign aw_region = '0;
  assign aw_qos    = '0;
  assign aw_user   = '0;
  assign w_data    = wdata_q;
  assign w_last    = 1'b1;
  assign w_user    = '0;
  assign ar_id     = '0;
  assign ar_addr   = AXI_ADDR_WIDTH'(addr_q);
  assign ar_len    = '0;
  assign ar_size   = 3'b010;
  assign ar_burst  = 2'b01;
  assign ar_lock   = 1'b0;
  assign ar_cache  = '0;
  assign ar_prot   = '0;
  assign ar_region = '0;
  assign ar_qos    = '0;
  assign ar_user   = '0;

endmodule

// File: tb/tb_apb2axi_bridge.sv
// Directed bench for apb2axi_bridge: APB master plus a cycle-scripted AXI slave.
module tb_apb2axi_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic        pwrite = 1'b0, psel = 1'b0, penable = 1'b0;
  logic [3:0]  pstrb = 4'hF;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [5:0]  aw_id, ar_id, aw_user, ar_user, w_user;
  logic [31:0] aw_addr, ar_addr, w_data;
  logic [7:0]  aw_len, ar_len;
  logic [2:0]  aw_size, ar_size, aw_prot, ar_prot;
  logic [1:0]  aw_burst, ar_burst;
  logic        aw_lock, ar_lock, aw_valid, ar_valid, w_valid, w_last, b_ready, r_ready;
  logic [3:0]  aw_cache, ar_cache, aw_region, ar_region, aw_qos, ar_qos, w_strb;
  logic        aw_ready = 1'b0, w_ready = 1'b0, ar_ready = 1'b0;
  logic [1:0]  b_resp = '0, r_resp = '0;
  logic        b_valid = 1'b0, r_valid = 1'b0, r_last = 1'b1;
  logic [31:0] r_data = '0;
  logic [5:0]  b_id = 6'h2A, r_id = 6'h15, b_user = 6'h3F, r_user = 6'h3F;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [40:0] FIXED_EXP = {6'd0, 8'd0, 3'b010, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 6'd0};

  apb2axi_bridge #(
    .AXI_ADDR_WIDTH(32), .AXI_ID_WIDTH(6), .AXI_USER_WIDTH(6), .APB_ADDR_WIDTH(32)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
`ifdef APB2AXI_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .aw_lock(aw_lock), .aw_cache(aw_cache), .aw_prot(aw_prot), .aw_region(aw_region),
    .aw_qos(aw_qos), .aw_user(aw_user), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_user(w_user), .w_valid(w_valid),
    .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_user(b_user), .b_valid(b_valid), .b_ready(b_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .ar_lock(ar_lock), .ar_cache(ar_cache), .ar_prot(ar_prot), .ar_region(ar_region),
    .ar_qos(ar_qos), .ar_user(ar_user), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_user(r_user),
    .r_valid(r_valid), .r_ready(r_ready)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apb_setup(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    tick();
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    tick();
    penable = 1'b1;
  endtask

  task automatic do_write(input string name, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input logic [1:0] bresp, input logic exp_err);
    int aw_hs, w_hs, b_hs, aw_cyc, w_cyc, pr_cnt, pr_at, other, exp_lat;
    logic [3:0] exp_strb;
    bit fin;
`ifdef APB2AXI_PSTRB_EN
    exp_strb = strb;
`else
    exp_strb = 4'hF;
`endif
    aw_hs = 0; w_hs = 0; b_hs = 0; aw_cyc = 0; w_cyc = 0; pr_cnt = 0; pr_at = -1; other = 0;
    fin = 1'b0;
    exp_lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly);
    apb_setup(1'b1, addr, data, strb);
    for (int c = 0; c < 40 && !fin; c++) begin
      if (pr_at >= 0) begin psel = 1'b0; penable = 1'b0; end
      aw_ready = (c >= 1 + aw_dly);
      w_ready  = (c >= 1 + w_dly);
      b_valid  = (aw_hs > 0 && w_hs > 0 && b_hs == 0);
      b_resp   = b_valid ? bresp : 2'b00;
      #1;
      if (aw_valid) aw_cyc++;
      if (aw_valid && aw_ready) begin
        aw_hs++;
        vectors++;
        if (aw_addr !== addr || {aw_id, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
            aw_region, aw_qos, aw_user} !== FIXED_EXP) begin
          miscompares++;
          $display("FAIL %s aw_payload: addr=%h fields=%h, expected addr=%h fields=%h",
                   name, aw_addr, {aw_id, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
                   aw_region, aw_qos, aw_user}, addr, FIXED_EXP);
        end
      end
      if (w_valid) w_cyc++;
      if (w_valid && w_ready) begin
        w_hs++;
        vectors++;
        if (w_data !== data || w_strb !== exp_strb || w_last !== 1'b1 || w_user !== 6'd0) begin
          miscompares++;
          $display("FAIL %s w_payload: data=%h strb=%h last=%b user=%h, expected data=%h strb=%h last=1 user=0",
                   name, w_data, w_strb, w_last, w_user, data, exp_strb);
        end
      end
      if (b_valid && b_ready) b_hs++;
      if (ar_valid || r_ready) other++;
      if (pready) begin
        pr_cnt++;
        pr_at = c;
        vectors++;
        if (pslverr !== exp_err || prdata !== 32'h0 || b_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL %s response: pslverr=%b prdata=%h b_ready=%b, expected pslverr=%b prdata=0 b_ready=0",
                   name, pslverr, prdata, b_ready, exp_err);
        end
      end else if (pr_at >= 0) fin = 1'b1;
      if (!fin) tick();
    end
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
    psel = 1'b0; penable = 1'b0;
    vectors++;
    if (pr_at != exp_lat || pr_cnt != 1) begin
      miscompares++;
      $display("FAIL %s pready_timing: at cycle %0d count %0d, expected cycle %0d count 1",
               name, pr_at, pr_cnt, exp_lat);
    end
    vectors++;
    if (aw_hs != 1 || w_hs != 1 || b_hs != 1 || aw_cyc != 1 + aw_dly || w_cyc != 1 + w_dly || other != 0) begin
      miscompares++;
      $display("FAIL %s handshakes: aw=%0d w=%0d b=%0d aw_cyc=%0d w_cyc=%0d rd_act=%0d, expected 1 1 1 %0d %0d 0",
               name, aw_hs, w_hs, b_hs, aw_cyc, w_cyc, other, 1 + aw_dly, 1 + w_dly);
    end
  endtask

  task automatic do_read(input string name, input logic [31:0] addr, input int ar_dly,
                         input logic [31:0] rdata, input logic [1:0] rresp, input logic rlast,
                         input logic exp_err);
    int ar_hs, r_hs, pr_cnt, pr_at, other;
    bit fin;
    ar_hs = 0; r_hs = 0; pr_cnt = 0; pr_at = -1; other = 0; fin = 1'b0;
    apb_setup(1'b0, addr, 32'hFFFF_FFFF, 4'hF);
    for (int c = 0; c < 40 && !fin; c++) begin
      if (pr_at >= 0) begin psel = 1'b0; penable = 1'b0; end
      ar_ready = (c >= 1 + ar_dly);
      r_valid  = (ar_hs > 0 && r_hs == 0);
      r_data   = r_valid ? rdata : 32'hBAD0_BAD0;
      r_resp   = r_valid ? rresp : 2'b11;
      r_last   = r_valid ? rlast : 1'b0;
      #1;
      if (ar_valid && ar_ready) begin
        ar_hs++;
        vectors++;
        if (ar_addr !== addr || {ar_id, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
            ar_region, ar_qos, ar_user} !== FIXED_EXP) begin
          miscompares++;
          $display("FAIL %s ar_payload: addr=%h fields=%h, expected addr=%h fields=%h",
                   name, ar_addr, {ar_id, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
                   ar_region, ar_qos, ar_user}, addr, FIXED_EXP);
        end
      end
      if (r_valid && r_ready) r_hs++;
      if (aw_valid || w_valid || b_ready) other++;
      if (pready) begin
        pr_cnt++;
        pr_at = c;
        vectors++;
        if (prdata !== rdata || pslverr !== exp_err || r_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL %s response: prdata=%h pslverr=%b r_ready=%b, expected prdata=%h pslverr=%b r_ready=0",
                   name, prdata, pslverr, r_ready, rdata, exp_err);
        end
      end else if (pr_at >= 0) fin = 1'b1;
      if (!fin) tick();
    end
    ar_ready = 1'b0; r_valid = 1'b0; psel = 1'b0; penable = 1'b0;
    vectors++;
    if (pr_at != 3 + ar_dly || pr_cnt != 1) begin
      miscompares++;
      $display("FAIL %s pready_timing: at cycle %0d count %0d, expected cycle %0d count 1",
               name, pr_at, pr_cnt, 3 + ar_dly);
    end
    vectors++;
    if (ar_hs != 1 || r_hs != 1 || other != 0) begin
      miscompares++;
      $display("FAIL %s handshakes: ar=%0d r=%0d wr_act=%0d, expected 1 1 0", name, ar_hs, r_hs, other);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick();
    vectors++;
    if ({aw_valid, w_valid, b_ready, ar_valid, r_ready, pready, pslverr} !== 7'b0 || prdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: ctl=%b prdata=%h, expected ctl=0000000 prdata=0",
               {aw_valid, w_valid, b_ready, ar_valid, r_ready, pready, pslverr}, prdata);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_write_basic();
    do_write("write_basic", 32'h1A00_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b00, 1'b0);
  endtask

  task automatic test_read_ar_delay();
    do_read("read_ar_delay", 32'h1A00_0020, 5, 32'h1234_5678, 2'b00, 1'b1, 1'b0);
  endtask

  task automatic test_write_w_delay();
    do_write("write_w_delay", 32'h0000_0444, 32'hA5A5_5A5A, 4'hF, 0, 3, 2'b00, 1'b0);
    do_write("write_aw_delay", 32'h0000_0888, 32'h0F0F_F0F0, 4'hF, 2, 0, 2'b01, 1'b0);
  endtask

  task automatic test_slverr();
    do_write("write_decerr", 32'h0000_0100, 32'h1111_2222, 4'hF, 0, 0, 2'b11, 1'b1);
    do_read("read_slverr", 32'h0000_0200, 0, 32'hCAFE_F00D, 2'b10, 1'b1, 1'b1);
    do_read("read_nolast", 32'h0000_0204, 1, 32'h7777_8888, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic test_reset_idle();
    // prdata/pslverr are still holding the last (error) read result here
    #2 rst_i = 1'b1;
    #1;
    vectors++;
    if (prdata !== 32'h0 || pslverr !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: prdata=%h pslverr=%b, expected prdata=0 pslverr=0", prdata, pslverr);
    end
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    bit seen;
    seen = 1'b0;
    apb_setup(1'b1, 32'h0000_0300, 32'h3333_4444, 4'hF);
    aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (b_ready) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL reset_mid_write_reach: b_ready never 1, expected WR_RESP within 20 cycles");
    end
    #2 rst_i = 1'b1;
    #1;
    vectors++;
    if ({aw_valid, w_valid, b_ready, ar_valid, r_ready, pready, pslverr} !== 7'b0 || prdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_write: ctl=%b prdata=%h, expected ctl=0000000 prdata=0",
               {aw_valid, w_valid, b_ready, ar_valid, r_ready, pready, pslverr}, prdata);
    end
    aw_ready = 1'b0; w_ready = 1'b0; psel = 1'b0; penable = 1'b0;
    tick();
    rst_i = 1'b0;
    do_read("read_after_reset", 32'h0000_0310, 0, 32'h9ABC_DEF0, 2'b00, 1'b1, 1'b0);
  endtask

  task automatic test_setup_only();
    tick();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0000_0500;
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++;
      if (aw_valid !== 1'b0 || w_valid !== 1'b0 || ar_valid !== 1'b0 || pready !== 1'b0) begin
        miscompares++;
        $display("FAIL setup_only cycle %0d: aw_valid=%b w_valid=%b ar_valid=%b pready=%b, expected all 0",
                 c, aw_valid, w_valid, ar_valid, pready);
      end
    end
    psel = 1'b0;
  endtask

  task automatic test_pstrb();
    do_write("write_strb_0011", 32'h0000_0600, 32'h5566_7788, 4'b0011, 0, 0, 2'b00, 1'b0);
    do_write("write_strb_0000", 32'h0000_0604, 32'h99AA_BBCC, 4'b0000, 1, 1, 2'b00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_ar_delay();
    test_write_w_delay();
    test_slverr();
    test_reset_idle();
    test_reset_mid_write();
    test_setup_only();
    test_pstrb();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
